// File: rtl/dff_bank_arbiter_if.sv
// Request/grant bus between the requesters and the shared-register arbiter.
// The master side is the requester pool; the slave side is the arbiter.
interface dff_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic                   busy;
  logic [ID_W-1:0]        owner;
  logic [CNT_W-1:0]       xfer_count;

  modport master (
    output req, data_in,
    input  grant, ack, q, busy, owner, xfer_count
  );

  modport slave (
    input  req, data_in,
    output grant, ack, q, busy, owner, xfer_count
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register: IDLE picks a requester,
// GRANT loads its lane into q and pulses ack, ACK advances the priority pointer.
module dff_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  dff_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t           state, state_next;
  logic [N_REQ-1:0] grant_r, grant_n;
  logic [N_REQ-1:0] ack_r, ack_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic [ID_W-1:0]  owner_r, owner_n;
  logic [ID_W-1:0]  last_r, last_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             busy_r;
  logic [ID_W-1:0]  pick, idx;
  logic             found;

  // Walk last+1, last+2, ... with explicit wrap so non-power-of-two N_REQ works.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = last_r;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      grant_r <= '0;
      ack_r   <= '0;
      q_r     <= '0;
      owner_r <= '0;
      last_r  <= ID_W'(N_REQ - 1);
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state   <= state_next;
      grant_r <= grant_n;
      ack_r   <= ack_n;
      q_r     <= q_n;
      owner_r <= owner_n;
      last_r  <= last_n;
      cnt_r   <= cnt_n;
      busy_r  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (found) state_next = GRANT;
      GRANT:   state_next = bus.req[owner_r] ? ACK : IDLE;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A requester that drops req during GRANT aborts without moving the pointer.
  always_comb begin
    grant_n = grant_r;
    ack_n   = '0;
    q_n     = q_r;
    owner_n = owner_r;
    last_n  = last_r;
    cnt_n   = cnt_r;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          owner_n       = pick;
        end
      end
      GRANT: begin
        if (bus.req[owner_r]) begin
          q_n            = bus.data_in[owner_r*WIDTH +: WIDTH];
          ack_n[owner_r] = 1'b1;
          cnt_n          = cnt_r + 1'b1;
        end else begin
          grant_n = '0;
        end
      end
      ACK: begin
        grant_n = '0;
        last_n  = owner_r;
      end
      default: begin
        grant_n = '0;
      end
    endcase
  end

  assign bus.grant      = grant_r;
  assign bus.ack        = ack_r;
  assign bus.q          = q_r;
  assign bus.busy       = busy_r;
  assign bus.owner      = owner_r;
  assign bus.xfer_count = cnt_r;

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin controller that shares one WIDTH-bit D flip-flop register, q, between N_REQ requesters.
- Each requester raises req with its data. The block grants one requester at a time, loads that requester's data into q, and returns a one-cycle ack.
- It sits in front of the shared state register. All writers to that register go through it, so there are no conflicting loads.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, width of the shared register and of each data lane.
- ID_W, 2, owner index width; must equal clog2(N_REQ).
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- req  input  N_REQ  per-requester write request, level.
- data_in  input  N_REQ*WIDTH  lane i is data_in[i*WIDTH +: WIDTH].
- grant  output  N_REQ  one-hot current owner; all zero when idle.
- ack  output  N_REQ  one-cycle pulse to the requester whose write completed.
- q  output  WIDTH  shared register contents.
- busy  output  1  high whenever state is not IDLE.
- owner  output  ID_W  index of the last granted requester.
- xfer_count  output  CNT_W  number of completed writes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset==0 at a rising edge), which overrides everything:
  - state=IDLE, q=0, grant=0, ack=0, busy=0, owner=0, xfer_count=0.
  - Internal priority pointer last=N_REQ-1, so requester 0 has highest priority first.
  - Reset asserted mid-transfer aborts it: no ack, and q is cleared.
- States are IDLE, GRANT and ACK. All outputs are registered.
- IDLE:
  - If no req bit is set, remain in IDLE.
  - Otherwise select the first set req bit searching last+1, last+2, … modulo N_REQ.
  - Set grant to that one-hot value, set owner to its index, and go to GRANT.
- GRANT (one cycle):
  - If req[owner] is still 1: q <= lane owner of data_in, ack[owner] <= 1, xfer_count <= xfer_count+1, go to ACK.
  - If req[owner] has dropped: abort. grant <= 0, q unchanged, no ack, last unchanged, go to IDLE.
- ACK (one cycle):
  - ack <= 0, grant <= 0, last <= owner, go to IDLE.
- Latency: req seen at edge E0 gives grant after E0, q and ack after E1, and ack cleared after E2.
  - Minimum spacing between successive transfers is 3 cycles.
  - Peak throughput is one write per 3 clocks.
- Handshake:
  - A requester holds req and a stable data lane until it sees ack, then drops req.
  - If it keeps req high, it is re-arbitrated behind the other active requesters (fairness by round robin).
- Data sampling: only data_in at edge E1 (the GRANT cycle) is loaded. Changes to data_in at any other time have no effect.
- Invariants:
  - grant is always one-hot or zero.
  - At most one ack bit is set in any cycle.
  - q changes only on a GRANT→ACK transition or on reset.
- Requests that arrive while busy are ignored until the state returns to IDLE. No request is lost while req is held.
- Counter: xfer_count wraps from 2^CNT_W-1 to 0 with no flag.
- Round-robin wrap: with last=N_REQ-1, the search starts at requester 0. With last=2 and N_REQ=4, the order is 3,0,1,2.

Test Plan:
1. Reset: hold reset=0 for 2 clocks with req=4'b1111 → q=0, grant=0, ack=0, busy=0, xfer_count=0.
2. Single write: req=4'b0100, lane2=8'hA5, reset=1 →
   - grant=4'b0100 after E0;
   - q=8'hA5 and ack=4'b0100 after E1;
   - ack=0 and grant=0 after E2;
   - xfer_count=1.
3. Round robin: hold req=4'b1111 with lanes 8'h10, 8'h21, 8'h32, 8'h43 →
   - acks occur in order 0,1,2,3,0, with q = 10, 21, 32, 43, 10 (hex);
   - acks are spaced 3 clocks apart.
4. Abort: req=4'b0010, then drop req[1] in the cycle after grant rises →
   - no ack, q unchanged, state back to IDLE;
   - next req=4'b0011 grants requester 0 (pointer not advanced).
5. Mid-transfer reset: req=4'b1000 with lane3=8'hFF, and reset=0 during GRANT →
   - no ack, q=0, state IDLE, xfer_count=0.
6. Counter wrap: use CNT_W=4 and run 17 transfers → xfer_count reads 15, then 0, then 1.
